// File: rtl/int_vctl.sv
// Vectored interrupt controller: NCHAN active-low request lines, per-line synchroniser,
// falling-edge pending latch and mask, fixed priority (channel 0 highest), latched vector.
module int_vctl #(
  parameter int NCHAN       = 8,
  parameter int VECW        = 3,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk4,
  input  logic             nreset,
  input  logic             nend,
  input  logic             ibus15,
  input  logic             nflagwe,
  input  logic [3:0]       action,
  input  logic [NCHAN-1:0] maskin,
  input  logic             nmaskwe,
  input  logic [NCHAN-1:0] nirq,
  output logic             fi,
  output logic             nirqs,
  output logic             nirqsuc,
  output logic [VECW-1:0]  vector,
  output logic [NCHAN-1:0] pending,
  output logic [1:0]       fsm_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SIGNAL = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] ACT_STI  = 4'h3;
  localparam logic [3:0] ACT_CLI  = 4'h4;
  localparam logic [3:0] ACT_INTA = 4'h5;

  state_t           state, state_next;
  logic [NCHAN-1:0] sync_q [SYNC_STAGES];
  logic [NCHAN-1:0] sync_d;
  logic [NCHAN-1:0] mask;
  logic [NCHAN-1:0] fall;
  logic [NCHAN-1:0] req_vec;
  logic [NCHAN-1:0] clr;
  logic [VECW-1:0]  win;
  logic             req;
  logic             is_sti, is_cli, is_inta;
  logic             load_vec;
  logic             fi_next;

  assign is_sti  = (action == ACT_STI);
  assign is_cli  = (action == ACT_CLI);
  assign is_inta = (action == ACT_INTA);

  // Synchroniser chain plus one extra flop on the last stage for edge detection.
  always_ff @(posedge clk4) begin
    if (!nreset) begin
      for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '1;
      sync_d <= '1;
    end else begin
      sync_q[0] <= nirq;
      for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign fall    = sync_d & ~sync_q[SYNC_STAGES-1];
  assign req_vec = pending & ~mask;
  assign req     = |req_vec;

  // Lowest requesting index wins.
  always_comb begin
    win = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (req_vec[i]) win = VECW'(i);
    end
  end

  always_comb begin
    clr = '0;
    if (state == SIGNAL && is_inta) begin
      for (int i = 0; i < NCHAN; i++) clr[i] = (vector == VECW'(i));
    end
  end

  // A fresh edge on the channel being acknowledged wins over the clear.
  always_ff @(posedge clk4) begin
    if (!nreset) begin
      pending <= '0;
    end else begin
      pending <= (pending & ~clr) | fall;
    end
  end

  always_ff @(posedge clk4) begin
    if (!nreset) begin
      mask <= '1;
    end else if (!nmaskwe) begin
      mask <= maskin;
    end
  end

  // INTA clears FI even outside SIGNAL; any recognised action beats a flag write.
  always_comb begin
    fi_next = fi;
    if (is_cli || is_inta) begin
      fi_next = 1'b0;
    end else if (is_sti) begin
      fi_next = 1'b1;
    end else if (!nflagwe) begin
      fi_next = ibus15;
    end
  end

  always_ff @(posedge clk4) begin
    if (!nreset) begin
      fi <= 1'b0;
    end else begin
      fi <= fi_next;
    end
  end

  // Handshake: nirqs goes low on entry to SIGNAL and holds with vector frozen until
  // the Control Unit answers with INTA (-> DONE) or CLI (-> IDLE); DONE forces one
  // high cycle before the next request can be raised.
  always_comb begin
    state_next = state;
    load_vec   = 1'b0;
    case (state)
      IDLE: begin
        if (fi && req && !nend) begin
          state_next = SIGNAL;
          load_vec   = 1'b1;
        end
      end
      SIGNAL: begin
        if (is_inta) begin
          state_next = DONE;
        end else if (is_cli) begin
          state_next = IDLE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk4) begin
    if (!nreset) begin
      state  <= IDLE;
      nirqs  <= 1'b1;
      vector <= '0;
    end else begin
      state <= state_next;
      nirqs <= (state_next != SIGNAL);
      if (load_vec) vector <= win;
    end
  end

  assign nirqsuc   = nirqs;
  assign fsm_state = state;

endmodule

// File: tb/tb_int_vctl.sv
// Scenario bench for int_vctl: expected snapshots are queued when stimulus is driven
// and compared against {state, fi, nirqs, nirqsuc, vector, pending} after each edge.
module tb_int_vctl;

  localparam int NCHAN = 8;
  localparam int VECW  = 3;
  localparam int W     = 16;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SIG  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [3:0] A_NONE = 4'h0;
  localparam logic [3:0] A_STI  = 4'h3;
  localparam logic [3:0] A_CLI  = 4'h4;
  localparam logic [3:0] A_INTA = 4'h5;

  logic             clk4;
  logic             nreset;
  logic             nend;
  logic             ibus15;
  logic             nflagwe;
  logic [3:0]       action;
  logic [NCHAN-1:0] maskin;
  logic             nmaskwe;
  logic [NCHAN-1:0] nirq;
  logic             fi;
  logic             nirqs;
  logic             nirqsuc;
  logic [VECW-1:0]  vector;
  logic [NCHAN-1:0] pending;
  logic [1:0]       fsm_state;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got;
  logic [W-1:0] exp_v;
  int           n_vec;
  int           n_err;

  int_vctl #(.NCHAN(NCHAN), .VECW(VECW), .SYNC_STAGES(2)) dut (
    .clk4      (clk4),
    .nreset    (nreset),
    .nend      (nend),
    .ibus15    (ibus15),
    .nflagwe   (nflagwe),
    .action    (action),
    .maskin    (maskin),
    .nmaskwe   (nmaskwe),
    .nirq      (nirq),
    .fi        (fi),
    .nirqs     (nirqs),
    .nirqsuc   (nirqsuc),
    .vector    (vector),
    .pending   (pending),
    .fsm_state (fsm_state)
  );

  // Clock and reset
  initial clk4 = 1'b0;
  always #5 clk4 = ~clk4;

  function automatic logic [W-1:0] mk(input logic [1:0] st, input logic f, input logic nq,
                                      input logic [VECW-1:0] v, input logic [NCHAN-1:0] p);
    return {st, f, nq, nq, v, p};
  endfunction

  function automatic logic [W-1:0] snap();
    return {fsm_state, fi, nirqs, nirqsuc, vector, pending};
  endfunction

  // Driver tasks
  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk4);
      #1;
    end
  endtask

  task automatic test_reset();
    nreset = 1'b0;
    tick(2);
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h00));
    nreset = 1'b1;
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL reset got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_fi_write();
    nflagwe = 1'b0; ibus15 = 1'b1;
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL fi_wr_set got=%h exp=%h", got, exp_v); end
    action = A_CLI;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL fi_cli_beats_wr got=%h exp=%h", got, exp_v); end
    action = A_STI; ibus15 = 1'b0;
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL fi_sti_beats_wr got=%h exp=%h", got, exp_v); end
    action = A_NONE;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL fi_wr_clr got=%h exp=%h", got, exp_v); end
    ibus15 = 1'b1; tick();
    nflagwe = 1'b1; action = A_INTA;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL fi_inta_idle got=%h exp=%h", got, exp_v); end
    action = A_NONE; ibus15 = 1'b0;
  endtask

  task automatic test_basic();
    action = A_STI; maskin = '0; nmaskwe = 1'b0;
    tick();
    action = A_NONE; nmaskwe = 1'b1;
    nirq[5] = 1'b0;
    tick();
    nirq[5] = 1'b1;
    tick();
    nend = 1'b0;
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd0, 8'h20)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL basic_pend got=%h exp=%h", got, exp_v); end
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd5, 8'h20)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL basic_signal got=%h exp=%h", got, exp_v); end
    action = A_INTA;
    exp_q.push_back(mk(S_DONE, 1'b0, 1'b1, 3'd5, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL basic_inta got=%h exp=%h", got, exp_v); end
    action = A_NONE;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd5, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL basic_done_idle got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_back_to_back();
    nirq[2] = 1'b0; nirq[6] = 1'b0; action = A_STI;
    tick();
    nirq[2] = 1'b1; nirq[6] = 1'b1; action = A_NONE;
    tick();
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd5, 8'h44)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_pend got=%h exp=%h", got, exp_v); end
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd2, 8'h44)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_prio got=%h exp=%h", got, exp_v); end
    action = A_INTA;
    exp_q.push_back(mk(S_DONE, 1'b0, 1'b1, 3'd2, 8'h40)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_inta1 got=%h exp=%h", got, exp_v); end
    action = A_STI;
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd2, 8'h40)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_gap got=%h exp=%h", got, exp_v); end
    action = A_NONE;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd6, 8'h40)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", got, exp_v); end
    action = A_INTA;
    exp_q.push_back(mk(S_DONE, 1'b0, 1'b1, 3'd6, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL b2b_inta2 got=%h exp=%h", got, exp_v); end
    action = A_NONE;
    tick();
  endtask

  task automatic test_fi_gate();
    nirq[1] = 1'b0;
    tick();
    nirq[1] = 1'b1;
    tick();
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd6, 8'h02)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL figate_pend got=%h exp=%h", got, exp_v); end
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd6, 8'h02)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL figate_hold got=%h exp=%h", got, exp_v); end
    action = A_STI; tick();
    action = A_NONE;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd1, 8'h02)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL figate_sti got=%h exp=%h", got, exp_v); end
    action = A_INTA; tick();
    action = A_NONE; tick();
  endtask

  task automatic test_mask();
    action = A_STI; maskin = 8'h08; nmaskwe = 1'b0;
    tick();
    action = A_NONE; nmaskwe = 1'b1;
    nirq[3] = 1'b0;
    tick();
    nirq[3] = 1'b1;
    tick();
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd1, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL mask_latch got=%h exp=%h", got, exp_v); end
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd1, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL mask_blocks got=%h exp=%h", got, exp_v); end
    maskin = '0; nmaskwe = 1'b0; nend = 1'b1;
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd1, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL mask_nend_hi got=%h exp=%h", got, exp_v); end
    nmaskwe = 1'b1; nend = 1'b0;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd3, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL mask_unmask got=%h exp=%h", got, exp_v); end
  endtask

  task automatic test_cli_coincident();
    action = A_CLI;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd3, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL cli_abort got=%h exp=%h", got, exp_v); end
    action = A_STI; tick();
    action = A_NONE;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd3, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL cli_resignal got=%h exp=%h", got, exp_v); end
    nirq[3] = 1'b0;
    tick();
    nirq[3] = 1'b1;
    tick();
    action = A_INTA;
    exp_q.push_back(mk(S_DONE, 1'b0, 1'b1, 3'd3, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL coincident_edge got=%h exp=%h", got, exp_v); end
    action = A_NONE; tick();
  endtask

  task automatic test_held_low();
    nirq[0] = 1'b0;
    tick(2);
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd3, 8'h09)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL held_pend got=%h exp=%h", got, exp_v); end
    action = A_STI; tick();
    action = A_NONE;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd0, 8'h09)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL held_signal got=%h exp=%h", got, exp_v); end
    action = A_INTA; tick();
    action = A_NONE;
    tick(2);
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL held_no_repend got=%h exp=%h", got, exp_v); end
    nirq[0] = 1'b1;
  endtask

  task automatic test_reset_mid_signal();
    action = A_STI; tick();
    action = A_NONE;
    exp_q.push_back(mk(S_SIG, 1'b1, 1'b0, 3'd3, 8'h08)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL rst_pre got=%h exp=%h", got, exp_v); end
    nreset = 1'b0;
    exp_q.push_back(mk(S_IDLE, 1'b0, 1'b1, 3'd0, 8'h00)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL rst_mid got=%h exp=%h", got, exp_v); end
    nreset = 1'b1;
    action = A_STI; tick();
    action = A_NONE;
    nirq[4] = 1'b0;
    tick();
    nirq[4] = 1'b1;
    tick();
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd0, 8'h10)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL rst_mask_pend got=%h exp=%h", got, exp_v); end
    exp_q.push_back(mk(S_IDLE, 1'b1, 1'b1, 3'd0, 8'h10)); tick();
    got = snap(); exp_v = exp_q.pop_front(); n_vec++;
    if (got !== exp_v) begin n_err++; $display("FAIL rst_mask_ones got=%h exp=%h", got, exp_v); end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    nreset = 1'b0; nend = 1'b1; ibus15 = 1'b0; nflagwe = 1'b1;
    action = A_NONE; maskin = '0; nmaskwe = 1'b1; nirq = '1;
    test_reset();
    test_fi_write();
    test_basic();
    test_back_to_back();
    test_fi_gate();
    test_mask();
    test_cli_coincident();
    test_held_low();
    test_reset_mid_signal();
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/int_vctl.md
Name: int_vctl

Overview:
- Parametrised successor to the single-line interrupt state machine.
- Accepts NCHAN active-low interrupt lines. Each line gets a synchroniser, a falling-edge detector, a pending latch and a mask bit.
- Arbitrates fixed priority (channel 0 highest). Signals the Control Unit at end of instruction, presents a latched vector and accepts a microcoded acknowledge.
- Sits between the bus IRQ lines and the Control Unit; keeps the FI flag, STI/CLI semantics and the paired IRQS/IRQµC outputs.

Parameters:
NCHAN, 8, number of interrupt channels (2..16)
VECW, 3, vector width; must satisfy 2^VECW >= NCHAN
SYNC_STAGES, 2, synchroniser flops per channel (>=2)

Ports:
clk4  in  1  system clock; all state updates on rising edge
nreset  in  1  synchronous, active-low reset, sampled on the clk4 rising edge
nend  in  1  active-low end-of-instruction, sampled on clk4
ibus15  in  1  FI write data
nflagwe  in  1  active-low FI write strobe, synchronous
action  in  4  microcode ACTION field: 4'h3=STI, 4'h4=CLI, 4'h5=INTA (acknowledge), others ignored
maskin  in  NCHAN  new mask value, 1=channel masked
nmaskwe  in  1  active-low mask write strobe, synchronous
nirq  in  NCHAN  active-low interrupt request lines, asynchronous
fi  out  1  interrupt enable flag
nirqs  out  1  active-low request to bus
nirqsuc  out  1  identical copy of nirqs for the Control Unit
vector  out  VECW  number of the signalled channel
pending  out  NCHAN  pending latch contents, for debug/status reads

Behaviour:
- Reset (nreset=0 at an edge) sets: fi=0, pending=0, mask=all ones, sync flops=1, vector=0, nirqs=nirqsuc=1, state IDLE. Reset overrides everything in the same cycle.
- Synchroniser: each nirq[i] passes through SYNC_STAGES flops s[0..S-1].
- Edge detector: a fall of s[S-1] (previous 1, now 0) sets pending[i]. nirq[i] low sampled at edge N sets pending[i] at edge N+S.
- Held-low lines: a line held low does not re-set pending after it is cleared; the device must release and re-assert.
- Pending clear: pending[i] is cleared only by INTA while vector==i. A new edge on i in the same cycle wins: pending stays 1.
- Mask: only gates arbitration; pending still latches masked edges. nmaskwe=0 loads maskin at the edge.
- FI write priority, highest first: reset, CLI (fi<=0), INTA (fi<=0, auto-disable on ISR entry), STI (fi<=1), nflagwe=0 (fi<=ibus15). Action beats nflagwe in the same cycle.
- req = |(pending & ~mask).
- FSM states:
  - IDLE, nirqs=1: if fi=1 and req=1 and nend=0 at the edge -> SIGNAL. On that transition vector <= lowest index i with pending[i]&~mask[i].
  - SIGNAL, nirqs=0, vector frozen:
    - INTA -> DONE; clears pending[vector] and fi.
    - CLI -> IDLE, pending untouched.
    - Newly arriving higher-priority requests and mask changes do not alter vector.
  - DONE, nirqs=1: unconditional -> IDLE next edge. Guarantees nirqs high for at least one cycle between requests.
- INTA outside SIGNAL: ignored except that it still clears fi.
- nirqs and nirqsuc: registered outputs, always equal. Asserted the edge after the IDLE->SIGNAL condition is sampled.
- Out-of-range channels: vector values >= NCHAN never occur.

Test Plan:
- Reset, fi=1 via STI, mask=0: pulse nirq[5] low at edge N; nend=0 from N+S onward -> pending[5]=1 at N+2, nirqs=0 and vector=5 at N+3. INTA -> pending[5]=0, fi=0, nirqs=1, DONE then IDLE.
- nirq[2] and nirq[6] fall in the same cycle -> vector=2. After INTA + STI, a second SIGNAL has vector=6.
- fi=0, nirq[1] falls -> pending[1]=1, nirqs stays 1. STI with nend=0 -> nirqs=0 next edge, vector=1.
- mask[3]=1, nirq[3] falls -> pending[3]=1, no request. Write mask=0 -> request raised at the next nend=0 edge.
- In SIGNAL, issue CLI -> nirqs=1 at the next edge, pending bit retained, fi=0. Edge on the signalled channel coincident with INTA -> pending stays 1.
- nreset=0 asserted mid-SIGNAL -> at the next edge all outputs return to reset values: pending=0, mask=all ones, nirqs=1.
